pc_unit: RTL and testbench



---
 rtl/pc_pkg.sv | 25 ++
 rtl/pc_unit_if.sv | 40 ++++
 rtl/pc_unit_ras_stack.sv | 91 +++++++++
 rtl/pc_unit.sv | 105 ++++++++++
 tb/tb_pc_unit.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/pc_pkg.sv
// -----------------------------------------------------------------------------
// pc_pkg
// Shared constants for the fetch-stage program-counter unit.
//   - Default PC width, sequential increment, reset and exception vectors.
//   - Encoding of the next-PC source chosen by the priority mux.
// No ports; imported by pc_unit_if, ras_stack and pc_unit.
// -----------------------------------------------------------------------------
package pc_pkg;

   localparam int          PC_W_DEF      = 32;
   localparam int          INC_DEF       = 4;
   localparam int          RAS_DEPTH_DEF = 4;
   localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
   localparam logic [31:0] EXC_VEC_DEF   = 32'h0000_0080;

   // Next-PC source, listed from highest to lowest priority.
   typedef logic [2:0] pcSrc_t;

   localparam pcSrc_t SRC_EXC   = 3'd0;
   localparam pcSrc_t SRC_REDIR = 3'd1;
   localparam pcSrc_t SRC_HOLD  = 3'd2;
   localparam pcSrc_t SRC_RAS   = 3'd3;
   localparam pcSrc_t SRC_SEQ   = 3'd4;

endpackage

// File: rtl/pc_unit_if.sv
// -----------------------------------------------------------------------------
// pc_unit_if
// Bundles the control inputs and status outputs of the program-counter unit.
//   stall, exc_req, redirect_valid, redirect_pc, call, ret : fetch control
//   pc_out, ras_count, ras_empty, ras_underflow            : PC unit status
// Modports:
//   master : the pipeline controller, drives control, observes status
//   slave  : the PC unit itself
// -----------------------------------------------------------------------------
interface pc_unit_if
   import pc_pkg::*;
#(
   parameter int PC_W      = PC_W_DEF,
   parameter int RAS_DEPTH = RAS_DEPTH_DEF
);

   localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

   logic             stall;
   logic             exc_req;
   logic             redirect_valid;
   logic [PC_W-1:0]  redirect_pc;
   logic             call;
   logic             ret;
   logic [PC_W-1:0]  pc_out;
   logic [CNT_W-1:0] ras_count;
   logic             ras_empty;
   logic             ras_underflow;

   modport master (
      output stall, exc_req, redirect_valid, redirect_pc, call, ret,
      input  pc_out, ras_count, ras_empty, ras_underflow
   );

   modport slave (
      input  stall, exc_req, redirect_valid, redirect_pc, call, ret,
      output pc_out, ras_count, ras_empty, ras_underflow
   );

endinterface

// File: rtl/pc_unit_ras_stack.sv
// -----------------------------------------------------------------------------
// ras_stack
// Circular return-address stack of DEPTH entries of W bits.
//   clk, rst      : clock and synchronous active-high reset
//   flush_i       : discard all entries (exception)
//   push_i        : write push_data_i as the new top
//   pop_i         : remove the top entry
//   push_data_i   : return address to push
//   top_o         : current top entry (meaningful only when count_o != 0)
//   count_o       : number of valid entries, saturates at DEPTH
// Pushing onto a full stack silently overwrites the oldest entry. Push and pop
// together on a non-empty stack replace the top in place.
// -----------------------------------------------------------------------------
module ras_stack #(
   parameter int DEPTH = 4,
   parameter int W     = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush_i,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic [W-1:0]               push_data_i,
   output logic [W-1:0]               top_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [W-1:0]     mem_q [DEPTH];
   logic [PTR_W-1:0] ptr_q;
   logic [PTR_W-1:0] ptr_d;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic [PTR_W-1:0] topIdx;
   logic [PTR_W-1:0] writeIdx;
   logic             writeEn;

   // The pointer marks the next free slot, so the top lives one below it.
   // DEPTH is a power of two, so pointer arithmetic wraps for free.
   assign topIdx  = ptr_q - PTR_W'(1);
   assign top_o   = mem_q[topIdx];
   assign count_o = count_q;

   // Decide where to write and how pointer/count move this cycle. A push
   // together with a pop on a non-empty stack is a replace of the top; on an
   // empty stack the pop has nothing to remove so it degrades to a push.
   always_comb begin
      ptr_d    = ptr_q;
      count_d  = count_q;
      writeEn  = 1'b0;
      writeIdx = ptr_q;
      if (flush_i) begin
         ptr_d   = '0;
         count_d = '0;
      end else if (push_i && pop_i && (count_q != '0)) begin
         writeEn  = 1'b1;
         writeIdx = topIdx;
      end else if (push_i) begin
         writeEn  = 1'b1;
         writeIdx = ptr_q;
         ptr_d    = ptr_q + PTR_W'(1);
         if (count_q != CNT_W'(DEPTH)) begin
            count_d = count_q + CNT_W'(1);
         end
      end else if (pop_i && (count_q != '0)) begin
         ptr_d   = topIdx;
         count_d = count_q - CNT_W'(1);
      end
   end

   // Pointer and occupancy registers; reset empties the stack.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q   <= '0;
         count_q <= '0;
      end else begin
         ptr_q   <= ptr_d;
         count_q <= count_d;
      end
   end

   // Entry storage needs no reset: an entry is only read while it is valid.
   always_ff @(posedge clk) begin
      if (writeEn && !rst) begin
         mem_q[writeIdx] <= push_data_i;
      end
   end

endmodule

// File: rtl/pc_unit.sv
// -----------------------------------------------------------------------------
// pc_unit
// Program counter for the MIPS fetch stage with return-address prediction.
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : pc_unit_if slave
//          in : stall, exc_req, redirect_valid, redirect_pc, call, ret
//          out: pc_out (registered fetch PC), ras_count, ras_empty,
//               ras_underflow (one-cycle pulse on ret with an empty stack)
// Next PC priority: exception, redirect, stall, RAS prediction, sequential.
// -----------------------------------------------------------------------------
module pc_unit
   import pc_pkg::*;
#(
   parameter int              PC_W      = PC_W_DEF,
   parameter logic [PC_W-1:0] RESET_VEC = PC_W'(RESET_VEC_DEF),
   parameter logic [PC_W-1:0] EXC_VEC   = PC_W'(EXC_VEC_DEF),
   parameter int              INC       = INC_DEF,
   parameter int              RAS_DEPTH = RAS_DEPTH_DEF
) (
   input logic       clk,
   input logic       rst,
   pc_unit_if.slave  bus
);

   localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

   logic [PC_W-1:0]  pc_q;
   logic [PC_W-1:0]  pc_d;
   logic             underflow_q;
   logic             underflow_d;
   logic [PC_W-1:0]  seqPc;
   logic [PC_W-1:0]  rasTop;
   logic [CNT_W-1:0] rasCount;
   logic             effCall;
   logic             effRet;
   logic             rasPop;
   pcSrc_t           nextSrc;

   assign seqPc = pc_q + PC_W'(INC);

   // A call still pushes under a redirect (jal/jalr resolve as redirects),
   // but a return is only predicted when nothing stronger steers the PC.
   assign effCall     = bus.call && !bus.exc_req && !bus.stall;
   assign effRet      = bus.ret && !bus.exc_req && !bus.redirect_valid && !bus.stall;
   assign rasPop      = effRet && (rasCount != '0);
   assign underflow_d = effRet && (rasCount == '0);

   ras_stack #(
      .DEPTH (RAS_DEPTH),
      .W     (PC_W)
   ) u_ras (
      .clk         (clk),
      .rst         (rst),
      .flush_i     (bus.exc_req),
      .push_i      (effCall),
      .pop_i       (rasPop),
      .push_data_i (seqPc),
      .top_o       (rasTop),
      .count_o     (rasCount)
   );

   // Pick the next-PC source in strict priority order.
   always_comb begin
      nextSrc = SRC_SEQ;
      if (bus.exc_req) begin
         nextSrc = SRC_EXC;
      end else if (bus.redirect_valid) begin
         nextSrc = SRC_REDIR;
      end else if (bus.stall) begin
         nextSrc = SRC_HOLD;
      end else if (rasPop) begin
         nextSrc = SRC_RAS;
      end
   end

   // Translate the chosen source into the next PC value.
   always_comb begin
      pc_d = seqPc;
      case (nextSrc)
         SRC_EXC:   pc_d = EXC_VEC;
         SRC_REDIR: pc_d = bus.redirect_pc;
         SRC_HOLD:  pc_d = pc_q;
         SRC_RAS:   pc_d = rasTop;
         default:   pc_d = seqPc;
      endcase
   end

   // PC and underflow pulse registers; reset overrides every other input.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q        <= RESET_VEC;
         underflow_q <= 1'b0;
      end else begin
         pc_q        <= pc_d;
         underflow_q <= underflow_d;
      end
   end

   assign bus.pc_out        = pc_q;
   assign bus.ras_count     = rasCount;
   assign bus.ras_empty     = (rasCount == '0);
   assign bus.ras_underflow = underflow_q;

endmodule

// File: tb/tb_pc_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_unit
// Self-checking bench for pc_unit: directed vectors with literal expectations
// plus a queue-based reference model compared against the DUT every cycle.
// -----------------------------------------------------------------------------
module tb_pc_unit;

   localparam int          DEPTH = 4;
   localparam logic [31:0] RVEC  = 32'h0000_0000;
   localparam logic [31:0] EVEC  = 32'h0000_0080;

   logic clk;
   logic rst;

   int assertCount;
   int failCount;

   logic [31:0] mPc;
   logic        mUf;
   logic [31:0] rasQ [$];
   logic        modelValid;

   pc_unit_if #(.PC_W(32), .RAS_DEPTH(DEPTH)) bus ();

   pc_unit #(
      .PC_W      (32),
      .RESET_VEC (RVEC),
      .EXC_VEC   (EVEC),
      .INC       (4),
      .RAS_DEPTH (DEPTH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison primitive shared by the model check and directed rows.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: actual %h required %h at %0t", name, actual, expected, $time);
      end
   endtask

   // Drive one cycle of inputs, advance the reference model at the rising
   // edge, and return on the following falling edge.
   task automatic applyStimulus(input logic r, input logic s, input logic e,
                                input logic rv, input logic [31:0] rpc,
                                input logic c, input logic rt);
      logic [31:0] seqV;
      logic [31:0] nextV;
      logic        effCall;
      logic        effRet;
      int          sizeBefore;
      rst                = r;
      bus.stall          = s;
      bus.exc_req        = e;
      bus.redirect_valid = rv;
      bus.redirect_pc    = rpc;
      bus.call           = c;
      bus.ret            = rt;
      @(posedge clk);
      if (r) begin
         mPc = RVEC;
         mUf = 1'b0;
         rasQ.delete();
         modelValid = 1'b1;
      end else begin
         seqV       = mPc + 32'd4;
         effCall    = c && !e && !s;
         effRet     = rt && !e && !rv && !s;
         sizeBefore = rasQ.size();
         mUf        = effRet && (sizeBefore == 0);
         if (e)                              nextV = EVEC;
         else if (rv)                        nextV = rpc;
         else if (s)                         nextV = mPc;
         else if (effRet && sizeBefore > 0)  nextV = rasQ[sizeBefore-1];
         else                                nextV = seqV;
         if (e) begin
            rasQ.delete();
         end else if (effCall && effRet && sizeBefore > 0) begin
            rasQ[sizeBefore-1] = seqV;
         end else if (effCall) begin
            rasQ.push_back(seqV);
            if (rasQ.size() > DEPTH) void'(rasQ.pop_front());
         end else if (effRet && sizeBefore > 0) begin
            void'(rasQ.pop_back());
         end
         mPc = nextV;
      end
      @(negedge clk);
   endtask

   // One directed row: stimulus followed by hand-computed expectations.
   task automatic runVector(input logic r, input logic s, input logic e,
                            input logic rv, input logic [31:0] rpc,
                            input logic c, input logic rt,
                            input logic [31:0] ePc, input int eCnt, input logic eUf);
      applyStimulus(r, s, e, rv, rpc, c, rt);
      checkOutput("vec_pc", bus.pc_out, ePc);
      checkOutput("vec_count", 32'(bus.ras_count), 32'(eCnt));
      checkOutput("vec_underflow", 32'(bus.ras_underflow), 32'(eUf));
   endtask

   // Every falling edge once the model is defined, hold the DUT to the model.
   always @(negedge clk) begin
      if (modelValid) begin
         checkOutput("model_pc", bus.pc_out, mPc);
         checkOutput("model_count", 32'(bus.ras_count), 32'(rasQ.size()));
         checkOutput("model_empty", 32'(bus.ras_empty), 32'(rasQ.size() == 0));
         checkOutput("model_underflow", 32'(bus.ras_underflow), 32'(mUf));
      end
   end

   // Directed scenario list: rst, stall, exc, redir, redir_pc, call, ret,
   // then expected pc, count, underflow after the edge.
   initial begin
      assertCount = 0;
      failCount   = 0;
      modelValid  = 1'b0;
      mPc         = '0;
      mUf         = 1'b0;
      rst                = 1'b1;
      bus.stall          = 1'b0;
      bus.exc_req        = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.call           = 1'b0;
      bus.ret            = 1'b0;

      runVector(1,0,0,0,32'h0,0,0, 32'h0, 0, 0);
      runVector(1,0,0,0,32'h0,0,0, 32'h0, 0, 0);
      runVector(0,0,0,0,32'h0,0,0, 32'h4, 0, 0);
      runVector(0,0,0,0,32'h0,0,0, 32'h8, 0, 0);
      runVector(0,1,0,0,32'h0,0,0, 32'h8, 0, 0);
      runVector(0,1,0,0,32'h0,0,0, 32'h8, 0, 0);
      runVector(0,1,0,0,32'h0,0,0, 32'h8, 0, 0);
      runVector(0,1,0,1,32'h40,0,0, 32'h40, 0, 0);
      runVector(0,0,0,0,32'h0,1,0, 32'h44, 1, 0);
      runVector(0,0,1,1,32'h300,0,0, 32'h80, 0, 0);

      runVector(0,0,0,1,32'h10,0,0, 32'h10, 0, 0);
      runVector(0,0,0,1,32'h100,1,0, 32'h100, 1, 0);
      runVector(0,0,0,0,32'h0,0,0, 32'h104, 1, 0);
      runVector(0,0,0,0,32'h0,0,1, 32'h14, 0, 0);
      runVector(0,0,0,0,32'h0,0,0, 32'h18, 0, 0);

      runVector(0,0,0,1,32'h0,0,0, 32'h0, 0, 0);
      runVector(0,0,0,1,32'h20,1,0, 32'h20, 1, 0);
      runVector(0,0,0,1,32'h40,1,0, 32'h40, 2, 0);
      runVector(0,0,0,1,32'h60,1,0, 32'h60, 3, 0);
      runVector(0,0,0,1,32'h80,1,0, 32'h80, 4, 0);
      runVector(0,0,0,1,32'h200,1,0, 32'h200, 4, 0);
      runVector(0,0,0,0,32'h0,0,1, 32'h84, 3, 0);
      runVector(0,0,0,0,32'h0,0,1, 32'h64, 2, 0);
      runVector(0,0,0,0,32'h0,0,1, 32'h44, 1, 0);
      runVector(0,0,0,0,32'h0,0,1, 32'h24, 0, 0);
      runVector(0,0,0,0,32'h0,0,1, 32'h28, 0, 1);
      runVector(0,0,0,0,32'h0,0,0, 32'h2c, 0, 0);

      runVector(0,0,0,1,32'h20,0,0, 32'h20, 0, 0);
      runVector(0,0,0,1,32'h40,1,0, 32'h40, 1, 0);
      runVector(0,0,0,1,32'h200,1,0, 32'h200, 2, 0);
      runVector(0,0,0,0,32'h0,1,1, 32'h44, 2, 0);
      runVector(0,0,0,0,32'h0,0,1, 32'h204, 1, 0);
      runVector(0,0,0,0,32'h0,0,1, 32'h24, 0, 0);

      runVector(0,1,0,0,32'h0,1,0, 32'h24, 0, 0);
      runVector(0,0,0,1,32'h500,0,1, 32'h500, 0, 0);
      runVector(0,0,0,0,32'h0,1,1, 32'h504, 1, 1);
      runVector(0,0,1,0,32'h0,1,1, 32'h80, 0, 0);

      runVector(0,0,0,1,32'hFFFF_FFFC,0,0, 32'hFFFF_FFFC, 0, 0);
      runVector(0,0,0,0,32'h0,0,0, 32'h0, 0, 0);
      runVector(0,0,0,0,32'h0,1,0, 32'h4, 1, 0);
      runVector(0,0,0,0,32'h0,1,0, 32'h8, 2, 0);
      runVector(1,0,0,0,32'h0,0,1, 32'h0, 0, 0);
      runVector(0,0,0,0,32'h0,0,1, 32'h4, 0, 1);
      runVector(1,0,0,0,32'h0,0,0, 32'h0, 0, 0);
      runVector(0,0,0,0,32'h0,0,0, 32'h4, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
